// File: rtl/io_disp_pkg.sv
// io_disp_pkg: shared FSM encoding, 7-segment codes and overflow limit helper
package io_disp_pkg;
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [9:0][6:0] SEG_CODES = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit plus blank flag to active-low {g..a} segment code
module seg7_decode
  import io_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  always_comb seg_o = blank_i ? SEG_BLANK : (bcd_i <= 4'd9 ? SEG_CODES[bcd_i] : SEG_DASH);
endmodule

// File: rtl/io_out_bcd_display.sv
// io_out_bcd_display: shows a CPU out_port word as decimal on 7-segment digits
module io_out_bcd_display
  import io_disp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_DIGITS = 6,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       value,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS) - 64'd1;
  state_t state_q, state_d;
  logic [DATA_W-1:0] last_q, last_d, sh_q, sh_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, done_q, done_d, ovf_q, ovf_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d, dec, rst_seg;
  logic [NUM_DIGITS-1:0] blank;
  logic z;
  always_comb begin
    adj = bcd_q;
    blank = '0;
    rst_seg = '0;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
      z = z && (bcd_q[4*i+:4] == 4'd0);
      blank[i] = BLANK_LZ && (i != 0) && z;
      rst_seg[7*i+:7] = (i == 0 || !BLANK_LZ) ? SEG_CODES[0] : SEG_BLANK;
    end
  end
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg7_decode u_dec (.bcd_i(bcd_q[4*i+:4]), .blank_i(blank[i]), .seg_o(dec[7*i+:7]));
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    sh_d = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    done_d = 1'b0;
    ovf_d = ovf_q;
    seg_d = seg_q;
    case (state_q)
      IDLE: begin
        pend_d = 64'(value) > LIMIT;
        if (value != last_q) begin
          last_d = value;
          sh_d = value;
          bcd_d = '0;
          cnt_d = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {adj[BW-2:0], sh_q[DATA_W-1]};
        sh_d = {sh_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(DATA_W - 1) ? LOAD : CONV;
      end
      LOAD: begin
        seg_d = pend_q ? {NUM_DIGITS{SEG_DASH}} : dec;
        ovf_d = pend_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= '0;
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      seg_q <= rst_seg;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      seg_q <= seg_d;
    end
  end
  assign seg = seg_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_io_out_bcd_display.sv
// tb_io_out_bcd_display: directed vector bench for the BCD display block
module tb_io_out_bcd_display;
  localparam logic [6:0] B = 7'b1111111, D = 7'b0111111;
  localparam logic [6:0] C0 = 7'b1000000, C1 = 7'b1111001, C2 = 7'b0100100, C3 = 7'b0110000;
  localparam logic [6:0] C4 = 7'b0011001, C5 = 7'b0010010, C6 = 7'b0000010, C7 = 7'b1111000;
  localparam logic [6:0] C9 = 7'b0010000;
  localparam logic [41:0] RST_SEG = {B, B, B, B, B, C0};
  typedef struct {
    logic [31:0] v;
    logic [41:0] s;
    logic        o;
  } vec_t;
  logic clock = 1'b0, reset = 1'b1, busy, done, ovf;
  logic [31:0] value = '0;
  logic [41:0] seg;
  int checks = 0, failures = 0;
  vec_t vecs[10];
  io_out_bcd_display dut (
    .clock(clock), .reset(reset), .value(value),
    .seg(seg), .busy(busy), .done(done), .ovf(ovf)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic run_conv(input logic [31:0] v, input logic [41:0] es, input logic eo, input string nm);
    logic [41:0] prev;
    int t, nb;
    bit stable;
    prev = seg;
    value = v;
    t = 0;
    nb = 0;
    stable = 1'b1;
    do begin
      step();
      t++;
      if (busy) nb++;
      if (!done && seg !== prev) stable = 1'b0;
    end while (!done && t < 60);
    chk({nm, "_latency"}, t, 34);
    chk({nm, "_busy_cycles"}, nb, 33);
    chk({nm, "_seg_hold"}, stable, 1);
    chk({nm, "_seg"}, seg, es);
    chk({nm, "_ovf"}, ovf, eo);
    step();
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_idle"}, busy, 0);
  endtask
  initial begin
    int t, nd, nb;
    vecs[0] = '{32'd123456, {C1, C2, C3, C4, C5, C6}, 1'b0};
    vecs[1] = '{32'd7, {B, B, B, B, B, C7}, 1'b0};
    vecs[2] = '{32'd100, {B, B, B, C1, C0, C0}, 1'b0};
    vecs[3] = '{32'd1000000, {D, D, D, D, D, D}, 1'b1};
    vecs[4] = '{32'd42, {B, B, B, B, C4, C2}, 1'b0};
    vecs[5] = '{32'd0, {B, B, B, B, B, C0}, 1'b0};
    vecs[6] = '{32'd999999, {C9, C9, C9, C9, C9, C9}, 1'b0};
    vecs[7] = '{32'hFFFFFFFF, {D, D, D, D, D, D}, 1'b1};
    vecs[8] = '{32'd5, {B, B, B, B, B, C5}, 1'b0};
    vecs[9] = '{32'd10, {B, B, B, B, C1, C0}, 1'b0};
    step();
    step();
    chk("reset_seg", seg, RST_SEG);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", ovf, 0);
    reset = 1'b0;
    nb = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (busy || done) nb++;
    end
    chk("zero_no_conv", nb, 0);
    chk("zero_seg", seg, RST_SEG);
    for (int i = 0; i < 10; i++) run_conv(vecs[i].v, vecs[i].s, vecs[i].o, $sformatf("vec%0d", i));
    value = 32'd11;
    t = 0;
    nd = 0;
    while (t < 100) begin
      step();
      t++;
      if (done) begin
        nd++;
        if (nd == 1) begin
          chk("ovl_first_latency", t, 34);
          chk("ovl_first_seg", seg, {B, B, B, B, C1, C1});
        end else if (nd == 2) begin
          chk("ovl_second_latency", t, 68);
          chk("ovl_second_seg", seg, {B, B, B, B, C9, C9});
        end
      end
      if (t == 10) value = 32'd99;
      if (t == 35) chk("ovl_restart_busy", busy, 1);
    end
    chk("ovl_done_count", nd, 2);
    value = 32'd555555;
    repeat (15) step();
    chk("mid_busy_before_reset", busy, 1);
    reset = 1'b1;
    step();
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_seg", seg, RST_SEG);
    chk("mid_reset_done", done, 0);
    chk("mid_reset_ovf", ovf, 0);
    reset = 1'b0;
    run_conv(32'd555555, {C5, C5, C5, C5, C5, C5}, 1'b0, "after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
